// File: rtl/alu_clk_en_ctrl.sv
// ALU clock-enable controller: wakes the gated ALU clock on request, lingers after each op.
// Optional CLK_GATE_STATS_EN adds stats_clr / on_cycles enabled-cycle accounting.
module alu_clk_en_ctrl #(
    parameter int WAKE_CYC    = 2,
    parameter int IDLE_HOLD   = 4,
    parameter int ALU_TIMEOUT = 8,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_req,
    input  logic        alu_out_valid,
`ifdef CLK_GATE_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] on_cycles,
`endif
    output logic        clk_en,
    output logic        op_ack,
    output logic        op_done,
    output logic        op_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD    = CNT_W'(WAKE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(ALU_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(IDLE_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             last_cycle;
    logic             clk_en_next;
    logic             op_ack_next;
    logic             op_done_next;
    logic             op_err_next;

    // The counter holds the cycles remaining in the current state, so a value of 1
    // (or an unexpected 0) marks the final cycle of WAKE, ACTIVE or HOLD.
    assign last_cycle = (cnt <= CNT_ONE);

    always_comb begin
        state_next   = state;
        cnt_next     = (cnt != '0) ? (cnt - CNT_ONE) : '0;
        op_ack_next  = 1'b0;
        op_done_next = 1'b0;
        op_err_next  = 1'b0;

        case (state)
            IDLE: begin
                if (op_req) begin
                    state_next = WAKE;
                    cnt_next   = WAKE_LD;
                end
            end
            WAKE: begin
                if (last_cycle) begin
                    state_next  = ACTIVE;
                    cnt_next    = TIMEOUT_LD;
                    op_ack_next = 1'b1;
                end
            end
            ACTIVE: begin
                // A result in the final permitted cycle still counts as a completion.
                if (alu_out_valid) begin
                    state_next   = HOLD;
                    cnt_next     = HOLD_LD;
                    op_done_next = 1'b1;
                end else if (last_cycle) begin
                    state_next  = HOLD;
                    cnt_next    = HOLD_LD;
                    op_err_next = 1'b1;
                end
            end
            HOLD: begin
                // A request arriving as the linger window expires still skips the wake-up.
                if (op_req) begin
                    state_next  = ACTIVE;
                    cnt_next    = TIMEOUT_LD;
                    op_ack_next = 1'b1;
                end else if (last_cycle) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        clk_en_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs come straight from flops so the gating cell never sees decode glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_en  <= 1'b0;
            op_ack  <= 1'b0;
            op_done <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            clk_en  <= clk_en_next;
            op_ack  <= op_ack_next;
            op_done <= op_done_next;
            op_err  <= op_err_next;
        end
    end

    assign busy = (state != IDLE);

`ifdef CLK_GATE_STATS_EN
    // Clear wins over increment; the count sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_cycles <= 16'd0;
        end else if (stats_clr) begin
            on_cycles <= 16'd0;
        end else if (clk_en && (on_cycles != 16'hFFFF)) begin
            on_cycles <= on_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_clk_en_ctrl.sv
// Testbench for alu_clk_en_ctrl: directed and random operation timelines against a planned expectation.
// Define CLK_GATE_STATS_EN to also exercise the on_cycles counter.
module tb_alu_clk_en_ctrl;

    localparam int WAKE_CYC    = 2;
    localparam int IDLE_HOLD   = 4;
    localparam int ALU_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int PLAN_MAX    = 256;
    localparam int PH_IDLE     = 0;
    localparam int PH_WAKE     = 1;
    localparam int PH_ACTIVE   = 2;
    localparam int PH_HOLD     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_req;
    logic        alu_out_valid;
    logic        clk_en;
    logic        op_ack;
    logic        op_done;
    logic        op_err;
    logic        busy;
`ifdef CLK_GATE_STATS_EN
    logic        stats_clr;
    logic [15:0] on_cycles;
    int          exp_on;
`endif

    int test_count = 0;
    int fail_count = 0;

    int phase      [PLAN_MAX];
    bit req_plan   [PLAN_MAX];
    bit valid_plan [PLAN_MAX];
    bit ack_exp    [PLAN_MAX];
    bit done_exp   [PLAN_MAX];
    bit err_exp    [PLAN_MAX];
    int anchor;
    int plan_len;
    bit have_prev;

    always #5 clk = ~clk;

    alu_clk_en_ctrl #(
        .WAKE_CYC   (WAKE_CYC),
        .IDLE_HOLD  (IDLE_HOLD),
        .ALU_TIMEOUT(ALU_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_req       (op_req),
        .alu_out_valid(alu_out_valid),
`ifdef CLK_GATE_STATS_EN
        .stats_clr    (stats_clr),
        .on_cycles    (on_cycles),
`endif
        .clk_en       (clk_en),
        .op_ack       (op_ack),
        .op_done      (op_done),
        .op_err       (op_err),
        .busy         (busy)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        test_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit req, input bit valid);
        op_req        = req;
        alu_out_valid = valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_plan(input int start);
        for (int c = 0; c < PLAN_MAX; c++) begin
            phase[c]      = PH_IDLE;
            req_plan[c]   = 1'b0;
            valid_plan[c] = 1'b0;
            ack_exp[c]    = 1'b0;
            done_exp[c]   = 1'b0;
            err_exp[c]    = 1'b0;
        end
        anchor    = start;
        have_prev = 1'b0;
    endfunction

    // One operation: request 'gap' cycles after the previous result (or plan start),
    // result 'lat' cycles after op_ack; lat >= ALU_TIMEOUT means the ALU never answers.
    function automatic void add_op(input int gap, input int lat);
        int t;
        int a;
        int d;
        bit from_hold;
        from_hold = have_prev && (gap < IDLE_HOLD);
        t = anchor + gap;
        if (have_prev)
            for (int c = anchor; c < anchor + IDLE_HOLD && c <= t; c++) phase[c] = PH_HOLD;
        req_plan[t] = 1'b1;
        if (from_hold) begin
            a = t + 1;
        end else begin
            for (int c = t + 1; c <= t + WAKE_CYC; c++) phase[c] = PH_WAKE;
            a = t + WAKE_CYC + 1;
        end
        ack_exp[a] = 1'b1;
        if (lat < ALU_TIMEOUT) begin
            valid_plan[a + lat] = 1'b1;
            d = a + lat + 1;
            done_exp[d] = 1'b1;
        end else begin
            d = a + ALU_TIMEOUT;
            err_exp[d] = 1'b1;
        end
        for (int c = a; c < d; c++) phase[c] = PH_ACTIVE;
        anchor    = d;
        have_prev = 1'b1;
    endfunction

    // Noise only where the inputs must be ignored: op_req in WAKE/ACTIVE, valid outside ACTIVE.
    function automatic void finish_plan(input bit noise);
        if (have_prev)
            for (int c = anchor; c < anchor + IDLE_HOLD; c++) phase[c] = PH_HOLD;
        plan_len = anchor + (have_prev ? IDLE_HOLD : 0) + 2;
        if (noise) begin
            for (int c = 0; c < plan_len; c++) begin
                if ((phase[c] == PH_WAKE || phase[c] == PH_ACTIVE) && $urandom_range(0, 2) == 0)
                    req_plan[c] = 1'b1;
                if (phase[c] != PH_ACTIVE && $urandom_range(0, 2) == 0)
                    valid_plan[c] = 1'b1;
            end
        end
    endfunction

    function automatic int count_enabled();
        int n;
        n = 0;
        for (int c = 0; c < plan_len; c++) if (phase[c] != PH_IDLE) n++;
        return n;
    endfunction

    task automatic run_plan(input string name, input int ncyc);
        int n;
        n = (ncyc < plan_len) ? ncyc : plan_len;
        for (int c = 0; c < n; c++) begin
            checkOutput($sformatf("%s c%0d clk_en", name, c), {15'd0, clk_en}, {15'd0, phase[c] != PH_IDLE});
            checkOutput($sformatf("%s c%0d busy", name, c), {15'd0, busy}, {15'd0, phase[c] != PH_IDLE});
            checkOutput($sformatf("%s c%0d op_ack", name, c), {15'd0, op_ack}, {15'd0, ack_exp[c]});
            checkOutput($sformatf("%s c%0d op_done", name, c), {15'd0, op_done}, {15'd0, done_exp[c]});
            checkOutput($sformatf("%s c%0d op_err", name, c), {15'd0, op_err}, {15'd0, err_exp[c]});
            applyStimulus(req_plan[c], valid_plan[c]);
            step();
        end
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, " clk_en"}, {15'd0, clk_en}, 16'd0);
        checkOutput({tag, " busy"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, " op_ack"}, {15'd0, op_ack}, 16'd0);
        checkOutput({tag, " op_done"}, {15'd0, op_done}, 16'd0);
        checkOutput({tag, " op_err"}, {15'd0, op_err}, 16'd0);
    endtask

    initial begin
        int nops;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
`ifdef CLK_GATE_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        rst = 1'b0;
        #1;
        check_quiet("reset");
        repeat (2) @(posedge clk);
        #7;
        rst = 1'b1;
        step();
        check_quiet("post_reset");

        // Scenario 1: single op, result two cycles after ack.
        clear_plan(0);
        add_op(0, 2);
        finish_plan(1'b0);
        run_plan("s1_basic", PLAN_MAX);

        // Scenario 2: ALU never answers.
        clear_plan(0);
        add_op(0, ALU_TIMEOUT);
        finish_plan(1'b0);
        run_plan("s2_timeout", PLAN_MAX);

        // Scenario 3: back-to-back op issued from HOLD.
        clear_plan(0);
        add_op(0, 2);
        add_op(1, 1);
        finish_plan(1'b0);
        run_plan("s3_hold_req", PLAN_MAX);

        // Scenario 4: request in the final HOLD cycle, result in the final ACTIVE cycle.
        clear_plan(0);
        add_op(0, 2);
        add_op(IDLE_HOLD - 1, ALU_TIMEOUT - 1);
        finish_plan(1'b0);
        run_plan("s4_boundary", PLAN_MAX);

        // Gap of exactly IDLE_HOLD: the clock must drop and a full wake-up follow.
        clear_plan(0);
        add_op(0, 0);
        add_op(IDLE_HOLD, 3);
        finish_plan(1'b0);
        run_plan("s4_rewake", PLAN_MAX);

        // Scenario 5: asynchronous reset mid-ACTIVE.
        clear_plan(0);
        add_op(0, ALU_TIMEOUT);
        finish_plan(1'b0);
        run_plan("s5_pre", 5);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("s5_async");
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_quiet($sformatf("s5_held%0d", k));
        end
        #3;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        step();
        check_quiet("s5_release");
        clear_plan(0);
        add_op(0, 2);
        finish_plan(1'b0);
        run_plan("s5_after", PLAN_MAX);

        // Randomised operation trains with ignored-input noise.
        for (int p = 0; p < 20; p++) begin
            nops = $urandom_range(1, 6);
            clear_plan(0);
            for (int k = 0; k < nops; k++)
                add_op((k == 0) ? 0 : int'($urandom_range(0, IDLE_HOLD + 3)),
                       int'($urandom_range(0, ALU_TIMEOUT + 1)));
            finish_plan(1'b1);
            run_plan($sformatf("rand%0d", p), PLAN_MAX);
        end

`ifdef CLK_GATE_STATS_EN
        // Scenario 6: enabled-cycle accounting, clear priority and saturation.
        #2;
        rst = 1'b0;
        #2;
        checkOutput("s6_reset on_cycles", on_cycles, 16'd0);
        rst = 1'b1;
        step();
        clear_plan(0);
        add_op(0, 2);
        finish_plan(1'b0);
        run_plan("s6_basic", PLAN_MAX);
        exp_on = count_enabled();
        checkOutput("s6_count on_cycles", on_cycles, exp_on[15:0]);
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        checkOutput("s6_pre_clr clk_en", {15'd0, clk_en}, 16'd1);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        checkOutput("s6_clr on_cycles", on_cycles, 16'd0);
        step();
        checkOutput("s6_after_clr on_cycles", on_cycles, 16'd1);
        applyStimulus(1'b1, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("s6_sat on_cycles", on_cycles, 16'hFFFF);
        applyStimulus(1'b0, 1'b0);
        repeat (ALU_TIMEOUT + IDLE_HOLD + 4) step();
        checkOutput("s6_idle busy", {15'd0, busy}, 16'd0);
        checkOutput("s6_hold on_cycles", on_cycles, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
